// File: rtl/stream_cipher_ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | stream_cipher_ctrl_if : session config and byte-stream handshake  |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
interface stream_cipher_ctrl_if #(
    parameter int LEN_W = 8
);
    logic [7:0]       cfg_seed;
    logic [LEN_W-1:0] cfg_len;
    logic             start;
    logic             busy;
    logic             done;
    logic             seed_err;
    logic [7:0]       in_data;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       out_data;
    logic             out_valid;
    logic             out_ready;

    modport slave (
        input  cfg_seed, cfg_len, start, in_data, in_valid, out_ready,
        output busy, done, seed_err, in_ready, out_data, out_valid
    );

    modport master (
        output cfg_seed, cfg_len, start, in_data, in_valid, out_ready,
        input  busy, done, seed_err, in_ready, out_data, out_valid
    );
endinterface
`default_nettype wire

// File: rtl/stream_cipher_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | stream_cipher_ctrl : LFSR keystream XOR session controller        |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
module stream_cipher_ctrl #(
    parameter logic [7:0] DEFAULT_SEED = 8'hAA,
    parameter int         LEN_W        = 8
) (
    input wire                  clk,
    input wire                  reset,
    stream_cipher_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam logic [LEN_W-1:0] c_len_one = {{(LEN_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [7:0]       lfsr_q, lfsr_d;
    logic [7:0]       out_data_q, out_data_d;
    logic [LEN_W-1:0] remaining_q, remaining_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             seed_err_q, seed_err_d;

    logic             w_in_ready;
    logic             w_accept;
    logic             w_out_fire;
    logic [7:0]       w_lfsr_next;

    assign w_lfsr_next = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    assign w_in_ready  = (state_q == ST_RUN) && (!out_valid_q || bus.out_ready);
    assign w_accept    = bus.in_valid && w_in_ready;
    assign w_out_fire  = out_valid_q && bus.out_ready;

    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        out_data_d  = out_data_q;
        remaining_d = remaining_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        seed_err_d  = seed_err_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bus.cfg_len != '0) begin
                        state_d     = ST_RUN;
                        busy_d      = 1'b1;
                        remaining_d = bus.cfg_len;
                        // A zero seed would lock the LFSR at zero, so substitute.
                        if (bus.cfg_seed == 8'h00) begin
                            lfsr_d     = DEFAULT_SEED;
                            seed_err_d = 1'b1;
                        end else begin
                            lfsr_d     = bus.cfg_seed;
                            seed_err_d = 1'b0;
                        end
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (w_out_fire) begin
                    out_valid_d = 1'b0;
                end
                if (w_accept) begin
                    out_data_d  = bus.in_data ^ lfsr_q;
                    out_valid_d = 1'b1;
                    lfsr_d      = w_lfsr_next;
                    remaining_d = remaining_q - c_len_one;
                    if (remaining_q == c_len_one) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (w_out_fire) begin
                    out_valid_d = 1'b0;
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            lfsr_q      <= DEFAULT_SEED;
            out_data_q  <= 8'h00;
            remaining_q <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            seed_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            out_data_q  <= out_data_d;
            remaining_q <= remaining_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            seed_err_q  <= seed_err_d;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.seed_err  = seed_err_q;
endmodule
`default_nettype wire

// File: tb/tb_stream_cipher_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_stream_cipher_ctrl : directed self-checking bench              |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
module tb_stream_cipher_ctrl;
    logic clk;
    logic reset;
    logic chain;
    logic out_ready_drv;
    int   n_checks;
    int   n_fail;
    int   done_cnt1;

    stream_cipher_ctrl_if #(.LEN_W(8)) if1 ();
    stream_cipher_ctrl_if #(.LEN_W(8)) if2 ();

    stream_cipher_ctrl #(.DEFAULT_SEED(8'hAA), .LEN_W(8)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (if1)
    );

    stream_cipher_ctrl #(.DEFAULT_SEED(8'hAA), .LEN_W(8)) u_dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (if2)
    );

    // Second instance decrypts whatever the first one produces.
    assign if2.in_data   = if1.out_data;
    assign if2.in_valid  = if1.out_valid;
    assign if1.out_ready = chain ? if2.in_ready : out_ready_drv;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (if1.done) done_cnt1 <= done_cnt1 + 1;
    end

    task automatic start1(input logic [7:0] seed, input logic [7:0] len);
        if1.cfg_seed = seed;
        if1.cfg_len  = len;
        if1.start    = 1'b1;
        @(negedge clk);
        if1.start    = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++; if (if1.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", if1.busy); end
        n_checks++; if (if1.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b, expected 0", if1.done); end
        n_checks++; if (if1.seed_err !== 1'b0) begin n_fail++; $display("FAIL reset_seed_err: got %b, expected 0", if1.seed_err); end
        n_checks++; if (if1.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b, expected 0", if1.in_ready); end
        n_checks++; if (if1.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b, expected 0", if1.out_valid); end
        n_checks++; if (if1.out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data: got %h, expected 00", if1.out_data); end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [7:0] pt [3];
        logic [7:0] ex [3];
        int         base;
        pt[0] = 8'h68; pt[1] = 8'h65; pt[2] = 8'h6C;
        ex[0] = 8'hC2; ex[1] = 8'h30; ex[2] = 8'hC7;
        base = done_cnt1;
        start1(8'hAA, 8'd3);
        n_checks++; if (if1.busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b, expected 1", if1.busy); end
        n_checks++; if (if1.seed_err !== 1'b0) begin n_fail++; $display("FAIL basic_seed_err: got %b, expected 0", if1.seed_err); end
        out_ready_drv = 1'b1;
        if1.in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if1.in_data = pt[i];
            #1;
            n_checks++; if (if1.in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_in_ready[%0d]: got %b, expected 1", i, if1.in_ready); end
            @(negedge clk);
            n_checks++;
            if ({if1.out_valid, if1.out_data} !== {1'b1, ex[i]}) begin
                n_fail++; $display("FAIL basic_out[%0d]: got valid=%b data=%h, expected valid=1 data=%h", i, if1.out_valid, if1.out_data, ex[i]);
            end
        end
        if1.in_valid = 1'b0;
        @(negedge clk);
        n_checks++; if ({if1.done, if1.busy} !== 2'b10) begin n_fail++; $display("FAIL basic_done: got done=%b busy=%b, expected done=1 busy=0", if1.done, if1.busy); end
        @(negedge clk);
        n_checks++; if (if1.done !== 1'b0) begin n_fail++; $display("FAIL basic_done_clear: got %b, expected 0", if1.done); end
        n_checks++; if (done_cnt1 - base !== 1) begin n_fail++; $display("FAIL basic_done_count: got %0d, expected 1", done_cnt1 - base); end
    endtask

    task automatic test_seed_zero();
        start1(8'h00, 8'd1);
        n_checks++; if ({if1.busy, if1.seed_err} !== 2'b11) begin n_fail++; $display("FAIL seed0_flags: got busy=%b seed_err=%b, expected 1 1", if1.busy, if1.seed_err); end
        if1.in_valid = 1'b1;
        if1.in_data  = 8'h00;
        @(negedge clk);
        n_checks++; if ({if1.out_valid, if1.out_data} !== {1'b1, 8'hAA}) begin n_fail++; $display("FAIL seed0_out: got valid=%b data=%h, expected valid=1 data=aa", if1.out_valid, if1.out_data); end
        if1.in_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (if1.done !== 1'b1) begin n_fail++; $display("FAIL seed0_done: got %b, expected 1", if1.done); end
        @(negedge clk);
    endtask

    task automatic test_stall();
        logic [7:0] ks [5];
        ks[0] = 8'hAA; ks[1] = 8'h55; ks[2] = 8'hAB; ks[3] = 8'h57; ks[4] = 8'hAF;
        start1(8'hAA, 8'd5);
        n_checks++; if (if1.seed_err !== 1'b0) begin n_fail++; $display("FAIL stall_seed_err_cleared: got %b, expected 0", if1.seed_err); end
        out_ready_drv = 1'b1;
        if1.in_valid  = 1'b1;
        if1.in_data   = 8'h00;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++; if (if1.out_data !== ks[i]) begin n_fail++; $display("FAIL stall_pre[%0d]: got %h, expected %h", i, if1.out_data, ks[i]); end
        end
        out_ready_drv = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++;
            if ({if1.out_valid, if1.out_data, if1.in_ready} !== {1'b1, 8'h55, 1'b0}) begin
                n_fail++; $display("FAIL stall_hold[%0d]: got valid=%b data=%h in_ready=%b, expected valid=1 data=55 in_ready=0", i, if1.out_valid, if1.out_data, if1.in_ready);
            end
            @(negedge clk);
        end
        out_ready_drv = 1'b1;
        for (int i = 2; i < 5; i++) begin
            @(negedge clk);
            n_checks++; if ({if1.out_valid, if1.out_data} !== {1'b1, ks[i]}) begin n_fail++; $display("FAIL stall_post[%0d]: got valid=%b data=%h, expected valid=1 data=%h", i, if1.out_valid, if1.out_data, ks[i]); end
        end
        #1;
        n_checks++; if (if1.in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_no_extra_accept: got %b, expected 0", if1.in_ready); end
        if1.in_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (if1.done !== 1'b1) begin n_fail++; $display("FAIL stall_done: got %b, expected 1", if1.done); end
        @(negedge clk);
    endtask

    task automatic test_zero_len();
        if1.in_valid = 1'b1;
        if1.in_data  = 8'h12;
        start1(8'h33, 8'd0);
        n_checks++;
        if ({if1.done, if1.busy, if1.in_ready} !== 3'b100) begin
            n_fail++; $display("FAIL zlen_pulse: got done=%b busy=%b in_ready=%b, expected 1 0 0", if1.done, if1.busy, if1.in_ready);
        end
        @(negedge clk);
        n_checks++;
        if ({if1.done, if1.busy, if1.in_ready, if1.out_valid} !== 4'b0000) begin
            n_fail++; $display("FAIL zlen_after: got done=%b busy=%b in_ready=%b out_valid=%b, expected all 0", if1.done, if1.busy, if1.in_ready, if1.out_valid);
        end
        if1.in_valid = 1'b0;
    endtask

    task automatic test_reset_abort();
        int base;
        base = done_cnt1;
        start1(8'hAA, 8'd5);
        out_ready_drv = 1'b1;
        if1.in_valid  = 1'b1;
        if1.in_data   = 8'h00;
        repeat (2) @(negedge clk);
        n_checks++; if (if1.out_data !== 8'h55) begin n_fail++; $display("FAIL abort_second_byte: got %h, expected 55", if1.out_data); end
        reset        = 1'b0;
        if1.in_valid = 1'b0;
        #1;
        n_checks++;
        if ({if1.busy, if1.out_valid, if1.in_ready, if1.out_data} !== {3'b000, 8'h00}) begin
            n_fail++; $display("FAIL abort_async: got busy=%b out_valid=%b in_ready=%b data=%h, expected 0 0 0 00", if1.busy, if1.out_valid, if1.in_ready, if1.out_data);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if (done_cnt1 - base !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d pulses, expected 0", done_cnt1 - base); end
        start1(8'h55, 8'd1);
        if1.in_valid = 1'b1;
        if1.in_data  = 8'h00;
        @(negedge clk);
        n_checks++; if ({if1.out_valid, if1.out_data} !== {1'b1, 8'h55}) begin n_fail++; $display("FAIL abort_fresh_key: got valid=%b data=%h, expected valid=1 data=55", if1.out_valid, if1.out_data); end
        if1.in_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (if1.done !== 1'b1) begin n_fail++; $display("FAIL abort_fresh_done: got %b, expected 1", if1.done); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back_chain();
        logic [8*13-1:0] s;
        logic [7:0]      msg [13];
        logic [7:0]      rx_data [13];
        int              idx;
        int              rx;
        int              cyc;
        logic            acc;
        s = "hello world !";
        for (int i = 0; i < 13; i++) begin
            msg[i]     = s[8*(12-i) +: 8];
            rx_data[i] = 8'h00;
        end
        chain         = 1'b1;
        if2.out_ready = 1'b1;
        if1.cfg_seed  = 8'h3C; if1.cfg_len = 8'd13;
        if2.cfg_seed  = 8'h3C; if2.cfg_len = 8'd13;
        if1.start     = 1'b1;  if2.start   = 1'b1;
        @(negedge clk);
        if1.start     = 1'b0;  if2.start   = 1'b0;
        idx = 0; rx = 0; cyc = 0;
        if1.in_valid = 1'b1;
        if1.in_data  = msg[0];
        while (rx < 13 && cyc < 200) begin
            #1;
            acc = if1.in_valid && if1.in_ready;
            if (if2.out_valid) begin
                rx_data[rx] = if2.out_data;
                rx++;
            end
            @(negedge clk);
            cyc++;
            if (acc) begin
                idx++;
                if (idx < 13) if1.in_data = msg[idx];
                else          if1.in_valid = 1'b0;
            end
        end
        n_checks++; if (rx !== 13) begin n_fail++; $display("FAIL chain_timeout: got %0d bytes, expected 13", rx); end
        for (int i = 0; i < 13; i++) begin
            n_checks++; if (rx_data[i] !== msg[i]) begin n_fail++; $display("FAIL chain_byte[%0d]: got %h, expected %h", i, rx_data[i], msg[i]); end
        end
        cyc = 0;
        while ((if1.busy || if2.busy) && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++; if ({if1.busy, if2.busy} !== 2'b00) begin n_fail++; $display("FAIL chain_idle: got busy1=%b busy2=%b, expected 0 0", if1.busy, if2.busy); end
        chain = 1'b0;
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        done_cnt1     = 0;
        reset         = 1'b0;
        chain         = 1'b0;
        out_ready_drv = 1'b0;
        if1.cfg_seed  = 8'h00; if1.cfg_len = 8'd0; if1.start = 1'b0;
        if1.in_data   = 8'h00; if1.in_valid = 1'b0;
        if2.cfg_seed  = 8'h00; if2.cfg_len = 8'd0; if2.start = 1'b0;
        if2.out_ready = 1'b0;

        test_reset();
        test_basic();
        test_seed_zero();
        test_stall();
        test_zero_len();
        test_reset_abort();
        test_back_to_back_chain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
